// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, R/W bit values
// and the default 7-bit device address.
package i2c_target_pkg;

  localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h1D;
  localparam logic       I2C_RW_WRITE         = 1'b0;
  localparam logic       I2C_RW_READ          = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus history flop for SCL/SDA, producing SCL edge
// strobes and START/STOP detection on the synchronized values.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] metastability stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_sr;
  logic [2:0] sda_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr <= '1;
      sda_sr <= '1;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_in};
      sda_sr <= {sda_sr[1:0], sda_in};
    end
  end

  assign sda       = sda_sr[1];
  assign scl_rise  = scl_sr[1] & ~scl_sr[2];
  assign scl_fall  = ~scl_sr[1] & scl_sr[2];
  assign start_det = scl_sr[1] & scl_sr[2] & sda_sr[2] & ~sda_sr[1];
  assign stop_det  = scl_sr[1] & scl_sr[2] & ~sda_sr[2] & sda_sr[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte register pointer and an internal register bank;
// open-drain SDA only, never stretches SCL.
//
// state        | meaning
// ST_IDLE      | bus free or not addressed
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for address
// ST_PTR       | shifting in register pointer
// ST_PTR_ACK   | driving ACK for pointer
// ST_WDATA     | shifting in a write byte
// ST_WDATA_ACK | driving ACK for a write byte
// ST_RDATA     | driving a read byte
// ST_RDATA_ACK | sampling controller ACK/NACK
// ST_IGNORE    | not for us, wait for START/STOP
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = I2C_DEV_ADDR_DEFAULT,
  parameter int         NUM_REGS  = 64,
  parameter int         PTR_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  input  logic                 loc_we,
  input  logic [PTR_WIDTH-1:0] loc_addr,
  input  logic [7:0]           loc_wdata,
  output logic                 wr_valid,
  output logic [PTR_WIDTH-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  logic [7:0] bank [NUM_REGS];

  state_t               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           tx_q, tx_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
  logic                 sda_oe_d, busy_d, wr_valid_d;
  logic [PTR_WIDTH-1:0] wr_addr_d;
  logic [7:0]           wr_data_d;
  logic                 i2c_we;
  logic [7:0]           rd_byte;
  logic                 byte_done;

  assign ptr_inc   = (ptr_q == PTR_WIDTH'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_WIDTH'(1);
  assign byte_done = (bit_cnt_q == 4'd8);
  assign rd_byte   = bank[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      wr_valid  <= wr_valid_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
    end
  end

  // Local port is written second so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (i2c_we && !rst) bank[ptr_q] <= shift_q;
    if (loc_we) bank[loc_addr] <= loc_wdata;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe;
    busy_d     = busy;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    i2c_we     = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        ST_RDATA_ACK: shift_d = {shift_q[6:0], sda_s};
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: if (byte_done) begin
          bit_cnt_d = '0;
          if (shift_q[7:1] == DEV_ADDR) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_ADDR_ACK;
          end else begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = ST_IGNORE;
          end
        end
        ST_ADDR_ACK: begin
          sda_oe_d = 1'b0;
          if (shift_q[0] == I2C_RW_READ) begin
            state_d   = ST_RDATA;
            sda_oe_d  = ~rd_byte[7];
            tx_d      = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else begin
            state_d = ST_PTR;
          end
        end
        ST_PTR: if (byte_done) begin
          ptr_d     = shift_q[PTR_WIDTH-1:0];
          sda_oe_d  = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_PTR_ACK;
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = ST_WDATA;
        end
        ST_WDATA: if (byte_done) begin
          i2c_we     = 1'b1;
          wr_valid_d = 1'b1;
          wr_addr_d  = ptr_q;
          wr_data_d  = shift_q;
          ptr_d      = ptr_inc;
          sda_oe_d   = 1'b1;
          bit_cnt_d  = '0;
          state_d    = ST_WDATA_ACK;
        end
        ST_RDATA: begin
          if (byte_done) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_inc;
            state_d  = ST_RDATA_ACK;
          end else begin
            sda_oe_d  = ~tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_RDATA_ACK: begin
          if (shift_q[0] == 1'b0) begin
            state_d   = ST_RDATA;
            sda_oe_d  = ~rd_byte[7];
            tx_d      = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged I2C controller, wr_valid
// scoreboard and per-scenario checks.
`timescale 1ns/1ps
module tb_i2c_target;
  import i2c_target_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_in;
  logic       sda_ctl;
  logic       sda_in;
  logic       sda_oe;
  logic       loc_we;
  logic [5:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       wr_valid;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_in = sda_ctl & ~sda_oe;

  i2c_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      logic [13:0] e;
      n_tests++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL wr_event: got addr %h data %h, expected addr %h data %h",
                   wr_addr, wr_data, e[13:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_ctl = 1'b1; wq();
    scl_in  = 1'b1; wq();
    sda_ctl = 1'b0; wq();
    scl_in  = 1'b0; wq();
  endtask

  task automatic bus_stop();
    sda_ctl = 1'b0; wq();
    scl_in  = 1'b1; wq();
    sda_ctl = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_ctl = b; wq();
    scl_in  = 1'b1; wq(); wq();
    scl_in  = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_ctl = 1'b1; wq();
    scl_in  = 1'b1; wq();
    b = sda_in; wq();
    scl_in  = 1'b0; wq();
  endtask

  // collide: fire loc_we on the exact clock the target commits this byte
  // (SCL fall reaches the core three clocks after the pin).
  task automatic write_byte(input logic [7:0] d, input logic collide, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (collide && i == 0) begin
        sda_ctl = d[0]; wq();
        scl_in  = 1'b1; wq(); wq();
        scl_in  = 1'b0;
        @(negedge clk); @(negedge clk);
        loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        repeat (Q - 3) @(negedge clk);
      end else begin
        write_bit(d[i]);
      end
    end
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_bit);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_in = 1'b1; sda_ctl = 1'b1;
    loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    repeat (5) @(negedge clk);
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe: got %b expected 0", sda_oe); end
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid: got %b expected 0", wr_valid); end
    n_tests++; if (wr_addr !== 6'h00) begin n_fail++; $display("FAIL rst_wr_addr: got %h expected 00", wr_addr); end
    n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data: got %h expected 00", wr_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic [3:0] acks;
    logic a;
    exp_wr.push_back({6'h10, 8'hA5});
    exp_wr.push_back({6'h11, 8'h5A});
    bus_start();
    write_byte(8'h3A, 1'b0, a); acks[3] = a;
    write_byte(8'h10, 1'b0, a); acks[2] = a;
    write_byte(8'hA5, 1'b0, a); acks[1] = a;
    write_byte(8'h5A, 1'b0, a); acks[0] = a;
    n_tests++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL write_acks: got %b expected 0000", acks); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_active: got %b expected 1", busy); end
    bus_stop();
    repeat (5) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    n_tests++; if (dut.bank[16] !== 8'hA5) begin n_fail++; $display("FAIL write_bank10: got %h expected a5", dut.bank[16]); end
    n_tests++; if (dut.bank[17] !== 8'h5A) begin n_fail++; $display("FAIL write_bank11: got %h expected 5a", dut.bank[17]); end
    n_tests++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL write_wr_missing: got %0d pending expected 0", exp_wr.size()); end
    exp_wr.delete();
  endtask

  task automatic test_combined_read();
    logic [2:0] acks;
    logic a;
    logic [7:0] d, e;
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h5A);
    bus_start();
    write_byte(8'h3A, 1'b0, a); acks[2] = a;
    write_byte(8'h10, 1'b0, a); acks[1] = a;
    bus_start();
    write_byte(8'h3B, 1'b0, a); acks[0] = a;
    n_tests++; if (acks !== 3'b000) begin n_fail++; $display("FAIL read_acks: got %b expected 000", acks); end
    read_byte(1'b0, d);
    e = exp_rd.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL read_byte0: got %h expected %h", d, e); end
    read_byte(1'b1, d);
    e = exp_rd.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL read_byte1: got %h expected %h", d, e); end
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack: got %b expected 0", sda_oe); end
    bus_stop();
    repeat (5) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    logic [1:0] acks;
    logic a;
    bus_start();
    write_byte(8'h40, 1'b0, a); acks[1] = a;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
    write_byte(8'h00, 1'b0, a); acks[0] = a;
    n_tests++; if (acks !== 2'b11) begin n_fail++; $display("FAIL mismatch_acks: got %b expected 11", acks); end
    bus_stop();
    repeat (5) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic [3:0] acks;
    logic a;
    exp_wr.push_back({6'h3F, 8'h11});
    exp_wr.push_back({6'h00, 8'h22});
    bus_start();
    write_byte(8'h3A, 1'b0, a); acks[3] = a;
    write_byte(8'h3F, 1'b0, a); acks[2] = a;
    write_byte(8'h11, 1'b0, a); acks[1] = a;
    write_byte(8'h22, 1'b0, a); acks[0] = a;
    bus_stop();
    repeat (5) @(negedge clk);
    n_tests++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL wrap_acks: got %b expected 0000", acks); end
    n_tests++; if (dut.bank[63] !== 8'h11) begin n_fail++; $display("FAIL wrap_bank3f: got %h expected 11", dut.bank[63]); end
    n_tests++; if (dut.bank[0] !== 8'h22) begin n_fail++; $display("FAIL wrap_bank00: got %h expected 22", dut.bank[0]); end
    n_tests++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL wrap_wr_missing: got %0d pending expected 0", exp_wr.size()); end
    exp_wr.delete();
  endtask

  task automatic test_local_collision();
    logic a;
    logic [7:0] d;
    loc_addr = 6'h05; loc_wdata = 8'h77;
    exp_wr.push_back({6'h05, 8'h99});
    bus_start();
    write_byte(8'h3A, 1'b0, a);
    write_byte(8'h05, 1'b0, a);
    write_byte(8'h99, 1'b1, a);
    bus_stop();
    repeat (5) @(negedge clk);
    n_tests++; if (dut.bank[5] !== 8'h77) begin n_fail++; $display("FAIL collide_bank05: got %h expected 77", dut.bank[5]); end
    n_tests++; if (wr_data !== 8'h99) begin n_fail++; $display("FAIL collide_wr_data: got %h expected 99", wr_data); end
    n_tests++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL collide_wr_missing: got %0d pending expected 0", exp_wr.size()); end
    exp_wr.delete();
    exp_rd.push_back(8'h77);
    bus_start();
    write_byte(8'h3A, 1'b0, a);
    write_byte(8'h05, 1'b0, a);
    bus_start();
    write_byte(8'h3B, 1'b0, a);
    read_byte(1'b1, d);
    bus_stop();
    n_tests++; if (d !== exp_rd[0]) begin n_fail++; $display("FAIL collide_readback: got %h expected %h", d, exp_rd[0]); end
    exp_rd.delete();
  endtask

  task automatic test_reset_mid_ack();
    logic a;
    logic [2:0] acks;
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] addr_byte;
      addr_byte = 8'h3A;
      write_bit(addr_byte[i]);
    end
    sda_ctl = 1'b1; wq();
    n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midack_driving: got %b expected 1", sda_oe); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midack_release: got %b expected 0", sda_oe); end
    n_tests++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL midack_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    rst = 1'b0;
    wq();
    bus_stop();
    wq();
    exp_wr.push_back({6'h20, 8'hC3});
    bus_start();
    write_byte(8'h3A, 1'b0, a); acks[2] = a;
    write_byte(8'h20, 1'b0, a); acks[1] = a;
    write_byte(8'hC3, 1'b0, a); acks[0] = a;
    bus_stop();
    repeat (5) @(negedge clk);
    n_tests++; if (acks !== 3'b000) begin n_fail++; $display("FAIL midack_after_acks: got %b expected 000", acks); end
    n_tests++; if (dut.bank[32] !== 8'hC3) begin n_fail++; $display("FAIL midack_after_bank20: got %h expected c3", dut.bank[32]); end
    n_tests++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL midack_wr_missing: got %0d pending expected 0", exp_wr.size()); end
    exp_wr.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_combined_read();
    test_addr_mismatch();
    test_wrap();
    test_local_collision();
    test_reset_mid_ack();
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
